// File: rtl/ysyx_23060203_csr_pkg.sv
// Shared CSR addresses, field positions and constants for the writeback/commit stage.
package ysyx_23060203_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MIE_MTIE       = 7;
  localparam int MIP_MTIP       = 7;

  localparam int IRQ_M_TIMER = 7;

  localparam logic [31:0] MVENDORID_VAL = 32'h7973_7978;
  localparam logic [31:0] MARCHID_VAL   = 32'h015f_deeb;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } wbu_state_e;

endpackage

// File: rtl/ysyx_23060203_csr_counter.sv
// 64-bit event counter with independent low/high half write ports.
module ysyx_23060203_csr_counter #(
  parameter int W = 32
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           inc,
  input  logic           wen_lo,
  input  logic           wen_hi,
  input  logic [W-1:0]   wdata,
  output logic [2*W-1:0] value
);

  logic [2*W-1:0] cnt;
  logic [2*W-1:0] cnt_inc;

  assign cnt_inc = cnt + {{(2*W-1){1'b0}}, inc};
  assign value   = cnt;

  // A write to one half replaces the increment; the other half simply holds.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt[W-1:0]   <= wen_lo ? wdata : (wen_hi ? cnt[W-1:0]   : cnt_inc[W-1:0]);
      cnt[2*W-1:W] <= wen_hi ? wdata : (wen_lo ? cnt[2*W-1:W] : cnt_inc[2*W-1:W]);
    end
  end

endmodule

// File: rtl/ysyx_23060203_wbu_trap.sv
// Writeback/commit stage: GPR write port, machine-mode CSRs, traps, timer IRQ, redirect.
//   state | meaning
//   RUN   | accepting retires from EXU
//   FLUSH | one-cycle redirect pulse to CSU, input stalled
module ysyx_23060203_wbu_trap
  import ysyx_23060203_csr_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int CAUSE_W        = 4,
  parameter int HAS_COUNTERS   = 1,
  parameter int MTVEC_VECTORED = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_pc,
  input  logic               in_gpr_wen,
  input  logic [4:0]         in_gpr_waddr,
  input  logic [XLEN-1:0]    in_gpr_wdata,
  input  logic               in_csr_wen,
  input  logic [11:0]        in_csr_waddr,
  input  logic [XLEN-1:0]    in_csr_wdata,
  input  logic               in_exc,
  input  logic [CAUSE_W-1:0] in_cause,
  input  logic               in_ret,
  input  logic               in_fencei,
  input  logic               irq_timer,
  input  logic [11:0]        csr_raddr,
  output logic [XLEN-1:0]    csr_rdata,
  output logic               gpr_wen,
  output logic [4:0]         gpr_waddr,
  output logic [XLEN-1:0]    gpr_wdata,
  output logic               cs_flush,
  output logic [XLEN-1:0]    cs_dnpc,
  output logic               fencei
);

  wbu_state_e state;
  logic flush_q, fencei_q;

  logic mst_mie, mst_mpie, mie_mtie;
  logic [XLEN-1:0] mtvec_q, mepc_q, mcause_q, mscratch_q;
  logic [2*XLEN-1:0] mcycle_v, minstret_v, mcycle_rd, minstret_rd;

  logic accept, irq_pending, redirect, csr_we;
  logic [XLEN-1:0] mtvec_base, normal_dnpc, target, mstatus_rd, mie_rd, mip_rd;

  assign in_ready    = (state == ST_RUN);
  assign accept      = in_valid & in_ready;
  assign irq_pending = irq_timer & mst_mie & mie_mtie;
  assign redirect    = accept & (in_exc | in_ret | in_csr_wen | in_fencei | irq_pending);
  assign csr_we      = accept & in_csr_wen & ~in_exc;

  assign gpr_wen   = accept & in_gpr_wen & ~in_exc & (in_gpr_waddr != 5'd0);
  assign gpr_waddr = in_gpr_waddr;
  assign gpr_wdata = in_gpr_wdata;

  assign mtvec_base  = {mtvec_q[XLEN-1:2], 2'b00};
  assign normal_dnpc = in_ret ? mepc_q : in_pc + XLEN'(4);

  always_comb begin
    target = in_pc + XLEN'(4);
    if (in_exc)
      target = mtvec_base;
    else if (in_ret)
      target = mepc_q;
    else if (irq_pending)
      target = mtvec_base + ((MTVEC_VECTORED != 0 && mtvec_q[0]) ? XLEN'(4 * IRQ_M_TIMER) : '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_RUN;
      flush_q  <= 1'b0;
      fencei_q <= 1'b0;
      cs_dnpc  <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (redirect) begin
            state    <= ST_FLUSH;
            flush_q  <= 1'b1;
            fencei_q <= in_fencei;
            cs_dnpc  <= target;
          end
        end
        ST_FLUSH: begin
          state    <= ST_RUN;
          flush_q  <= 1'b0;
          fencei_q <= 1'b0;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Reset during the flush cycle swallows the pending pulse.
  assign cs_flush = flush_q & ~reset;
  assign fencei   = fencei_q & ~reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      mst_mie    <= 1'b0;
      mst_mpie   <= 1'b0;
      mie_mtie   <= 1'b0;
      mtvec_q    <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mscratch_q <= '0;
    end else if (accept) begin
      if (in_exc) begin
        mepc_q   <= in_pc;
        mcause_q <= XLEN'(in_cause);
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
      end else begin
        if (csr_we) begin
          case (in_csr_waddr)
            CSR_MSTATUS: begin
              mst_mie  <= in_csr_wdata[MSTATUS_MIE];
              mst_mpie <= in_csr_wdata[MSTATUS_MPIE];
            end
            CSR_MIE:      mie_mtie   <= in_csr_wdata[MIE_MTIE];
            CSR_MTVEC:    mtvec_q    <= {in_csr_wdata[XLEN-1:2], 1'b0,
                                         (MTVEC_VECTORED != 0) & in_csr_wdata[0]};
            CSR_MEPC:     mepc_q     <= {in_csr_wdata[XLEN-1:2], 2'b00};
            CSR_MCAUSE:   mcause_q   <= in_csr_wdata;
            CSR_MSCRATCH: mscratch_q <= in_csr_wdata;
            default: ;
          endcase
        end
        if (in_ret) begin
          mst_mie  <= mst_mpie;
          mst_mpie <= 1'b1;
        end
        // Interrupt entry lands after the instruction's own CSR/mret effects.
        if (irq_pending) begin
          mepc_q   <= normal_dnpc;
          mcause_q <= {1'b1, (XLEN-1)'(IRQ_M_TIMER)};
          mst_mpie <= mst_mie;
          mst_mie  <= 1'b0;
        end
      end
    end
  end

  ysyx_23060203_csr_counter #(.W(XLEN)) u_mcycle (
    .clock  (clock),
    .reset  (reset),
    .inc    (1'b1),
    .wen_lo (csr_we && in_csr_waddr == CSR_MCYCLE),
    .wen_hi (csr_we && in_csr_waddr == CSR_MCYCLEH),
    .wdata  (in_csr_wdata),
    .value  (mcycle_v)
  );

  ysyx_23060203_csr_counter #(.W(XLEN)) u_minstret (
    .clock  (clock),
    .reset  (reset),
    .inc    (accept & ~in_exc),
    .wen_lo (csr_we && in_csr_waddr == CSR_MINSTRET),
    .wen_hi (csr_we && in_csr_waddr == CSR_MINSTRETH),
    .wdata  (in_csr_wdata),
    .value  (minstret_v)
  );

  assign mcycle_rd   = (HAS_COUNTERS != 0) ? mcycle_v   : '0;
  assign minstret_rd = (HAS_COUNTERS != 0) ? minstret_v : '0;

  always_comb begin
    mstatus_rd                     = '0;
    mstatus_rd[MSTATUS_MIE]        = mst_mie;
    mstatus_rd[MSTATUS_MPIE]       = mst_mpie;
    mstatus_rd[MSTATUS_MPP_LO+:2]  = 2'b11;
    mie_rd                         = '0;
    mie_rd[MIE_MTIE]               = mie_mtie;
    mip_rd                         = '0;
    mip_rd[MIP_MTIP]               = irq_timer;
  end

  always_comb begin
    case (csr_raddr)
      CSR_MSTATUS:   csr_rdata = mstatus_rd;
      CSR_MIE:       csr_rdata = mie_rd;
      CSR_MTVEC:     csr_rdata = mtvec_q;
      CSR_MSCRATCH:  csr_rdata = mscratch_q;
      CSR_MEPC:      csr_rdata = mepc_q;
      CSR_MCAUSE:    csr_rdata = mcause_q;
      CSR_MIP:       csr_rdata = mip_rd;
      CSR_MCYCLE:    csr_rdata = mcycle_rd[XLEN-1:0];
      CSR_MCYCLEH:   csr_rdata = mcycle_rd[2*XLEN-1:XLEN];
      CSR_MINSTRET:  csr_rdata = minstret_rd[XLEN-1:0];
      CSR_MINSTRETH: csr_rdata = minstret_rd[2*XLEN-1:XLEN];
      CSR_MVENDORID: csr_rdata = XLEN'(MVENDORID_VAL);
      CSR_MARCHID:   csr_rdata = XLEN'(MARCHID_VAL);
      default:       csr_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060203_wbu_trap.sv
// Scoreboard bench: stimulus pushes expected GPR writes and redirects, a negedge monitor pops them.
module tb_ysyx_23060203_wbu_trap;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid, in_ready;
  logic [31:0] in_pc;
  logic        in_gpr_wen;
  logic [4:0]  in_gpr_waddr;
  logic [31:0] in_gpr_wdata;
  logic        in_csr_wen;
  logic [11:0] in_csr_waddr;
  logic [31:0] in_csr_wdata;
  logic        in_exc;
  logic [3:0]  in_cause;
  logic        in_ret, in_fencei, irq_timer;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        cs_flush;
  logic [31:0] cs_dnpc;
  logic        fencei;

  int checks   = 0;
  int failures = 0;

  typedef struct { logic [4:0] a; logic [31:0] d; } gexp_t;
  typedef struct { logic [31:0] dnpc; logic fi; } fexp_t;
  gexp_t gq[$];
  fexp_t fq[$];

  always #5 clock = ~clock;

  ysyx_23060203_wbu_trap dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_gpr_wen(in_gpr_wen), .in_gpr_waddr(in_gpr_waddr), .in_gpr_wdata(in_gpr_wdata),
    .in_csr_wen(in_csr_wen), .in_csr_waddr(in_csr_waddr), .in_csr_wdata(in_csr_wdata),
    .in_exc(in_exc), .in_cause(in_cause), .in_ret(in_ret), .in_fencei(in_fencei),
    .irq_timer(irq_timer), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .cs_flush(cs_flush), .cs_dnpc(cs_dnpc), .fencei(fencei)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (gpr_wen === 1'b1) begin
      checks++;
      if (gq.size() == 0) begin
        failures++;
        $display("FAIL gpr_unexpected actual=%0d/%h required=none", gpr_waddr, gpr_wdata);
      end else begin
        gexp_t g;
        g = gq.pop_front();
        if (gpr_waddr !== g.a || gpr_wdata !== g.d) begin
          failures++;
          $display("FAIL gpr_write actual=%0d/%h required=%0d/%h", gpr_waddr, gpr_wdata, g.a, g.d);
        end
      end
    end
    if (cs_flush === 1'b1) begin
      checks++;
      if (fq.size() == 0) begin
        failures++;
        $display("FAIL flush_unexpected actual=%h required=none", cs_dnpc);
      end else begin
        fexp_t f;
        f = fq.pop_front();
        if (cs_dnpc !== f.dnpc || fencei !== f.fi) begin
          failures++;
          $display("FAIL flush actual=%h/%b required=%h/%b", cs_dnpc, fencei, f.dnpc, f.fi);
        end
      end
    end else if (fencei === 1'b1) begin
      checks++;
      failures++;
      $display("FAIL fencei_alone actual=1 required=0");
    end
  end

  task automatic clr();
    in_valid = 0; in_pc = '0; in_gpr_wen = 0; in_gpr_waddr = '0; in_gpr_wdata = '0;
    in_csr_wen = 0; in_csr_waddr = '0; in_csr_wdata = '0; in_exc = 0; in_cause = '0;
    in_ret = 0; in_fencei = 0;
  endtask

  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr_raddr = a;
    #1;
    chk(name, csr_rdata, exp);
  endtask

  // Present the staged instruction; eg/ef: expect GPR write / redirect with edn, efi.
  task automatic go(input bit eg, input bit ef, input logic [31:0] edn, input bit efi);
    int n = 0;
    @(posedge clock); #1;
    while (in_ready !== 1'b1 && n < 8) begin
      @(posedge clock); #1;
      n++;
    end
    chk("ready_wait", {31'b0, in_ready}, 32'd1);
    if (eg) gq.push_back('{in_gpr_waddr, in_gpr_wdata});
    if (ef) fq.push_back('{edn, efi});
    in_valid = 1;
    @(posedge clock); #1;
    clr();
    chk("ready_after", {31'b0, in_ready}, ef ? 32'd0 : 32'd1);
  endtask

  task automatic csrw(input logic [31:0] pc, input logic [11:0] a, input logic [31:0] d);
    clr();
    in_pc = pc; in_csr_wen = 1; in_csr_waddr = a; in_csr_wdata = d;
    go(0, 1, pc + 32'd4, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    irq_timer = 0;
    csr_raddr = '0;
    reset = 1;
    repeat (3) @(posedge clock);
    #1 reset = 0;

    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_flush", {31'b0, cs_flush}, 32'd0);
    chk("rst_dnpc", cs_dnpc, 32'd0);
    rd("rst_mstatus", 12'h300, 32'h0000_1800);
    rd("rst_mepc", 12'h341, 32'd0);
    rd("mvendorid", 12'hF11, 32'h7973_7978);
    rd("marchid", 12'hF12, 32'h015f_deeb);
    rd("unknown_csr", 12'h7C0, 32'd0);

    // addi x5 -> GPR write, no redirect
    clr(); in_pc = 32'h8000_0000; in_gpr_wen = 1; in_gpr_waddr = 5; in_gpr_wdata = 32'h10;
    go(1, 0, 0, 0);
    rd("minstret_1", 12'hB02, 32'd1);
    rd("minstreth_1", 12'hB82, 32'd0);

    // write to x0 is suppressed
    clr(); in_pc = 32'h8000_0004; in_gpr_wen = 1; in_gpr_waddr = 0; in_gpr_wdata = 32'hdead;
    go(0, 0, 0, 0);

    csrw(32'h8000_0004, 12'h305, 32'h8000_0100);
    rd("mtvec", 12'h305, 32'h8000_0100);

    // ecall with a GPR and CSR write attached: both dropped
    clr(); in_pc = 32'h8000_0040; in_exc = 1; in_cause = 4'd11;
    in_gpr_wen = 1; in_gpr_waddr = 7; in_gpr_wdata = 32'h55;
    in_csr_wen = 1; in_csr_waddr = 12'h340; in_csr_wdata = 32'h1234;
    go(0, 1, 32'h8000_0100, 0);
    rd("ecall_mepc", 12'h341, 32'h8000_0040);
    rd("ecall_mcause", 12'h342, 32'd11);
    rd("ecall_mstatus", 12'h300, 32'h0000_1800);
    rd("ecall_mscratch", 12'h340, 32'd0);
    rd("ecall_minstret", 12'hB02, 32'd3);

    csrw(32'h8000_0100, 12'h341, 32'h8000_0047);
    rd("mepc_align", 12'h341, 32'h8000_0044);
    csrw(32'h8000_0104, 12'h300, 32'h0000_0080);
    rd("mstatus_w", 12'h300, 32'h0000_1880);

    clr(); in_pc = 32'h8000_0108; in_ret = 1;
    go(0, 1, 32'h8000_0044, 0);
    rd("mret_mstatus", 12'h300, 32'h0000_1888);

    csrw(32'h8000_0044, 12'h304, 32'h0000_0080);
    rd("mie", 12'h304, 32'h0000_0080);
    irq_timer = 1;
    rd("mip", 12'h344, 32'h0000_0080);

    // timer interrupt on a plain retire; the instruction's GPR write still lands
    clr(); in_pc = 32'h8000_0200; in_gpr_wen = 1; in_gpr_waddr = 6; in_gpr_wdata = 32'h77;
    go(1, 1, 32'h8000_0100, 0);
    rd("irq_mepc", 12'h341, 32'h8000_0204);
    rd("irq_mcause", 12'h342, 32'h8000_0007);
    rd("irq_mstatus", 12'h300, 32'h0000_1880);

    // exception wins over a pending interrupt
    csrw(32'h8000_0100, 12'h300, 32'h0000_0008);
    rd("mstatus_mie", 12'h300, 32'h0000_1808);
    clr(); in_pc = 32'h8000_0300; in_exc = 1; in_cause = 4'd11;
    go(0, 1, 32'h8000_0100, 0);
    rd("excirq_mcause", 12'h342, 32'd11);
    rd("excirq_mepc", 12'h341, 32'h8000_0300);
    rd("excirq_mstatus", 12'h300, 32'h0000_1880);

    // MIE now clear: irq_timer high but no redirect
    clr(); in_pc = 32'h8000_0104; in_gpr_wen = 1; in_gpr_waddr = 8; in_gpr_wdata = 32'h99;
    go(1, 0, 0, 0);
    irq_timer = 0;

    // mcycle: write beats increment, then 64-bit wrap
    csrw(32'h8000_0108, 12'hB80, 32'hFFFF_FFFF);
    csrw(32'h8000_010C, 12'hB00, 32'hFFFF_FFFF);
    rd("mcycle_wr", 12'hB00, 32'hFFFF_FFFF);
    rd("mcycleh_wr", 12'hB80, 32'hFFFF_FFFF);
    @(posedge clock); #1;
    rd("mcycle_wrap", 12'hB00, 32'd0);
    rd("mcycleh_wrap", 12'hB80, 32'd0);

    csrw(32'h8000_0110, 12'hB02, 32'hFFFF_FFFF);
    csrw(32'h8000_0114, 12'hB82, 32'hFFFF_FFFF);
    rd("minstret_wr", 12'hB02, 32'hFFFF_FFFF);
    rd("minstreth_wr", 12'hB82, 32'hFFFF_FFFF);
    clr(); in_pc = 32'h8000_0118;
    go(0, 0, 0, 0);
    rd("minstret_wrap", 12'hB02, 32'd0);
    rd("minstreth_wrap", 12'hB82, 32'd0);

    clr(); in_pc = 32'h0000_0100; in_fencei = 1;
    go(0, 1, 32'h0000_0104, 1);

    // fence.i whose flush cycle coincides with reset: no pulse
    @(posedge clock); #1;
    chk("pre_rst_ready", {31'b0, in_ready}, 32'd1);
    clr(); in_pc = 32'h0000_0200; in_fencei = 1; in_valid = 1;
    @(posedge clock); #1;
    clr();
    reset = 1;
    #1;
    chk("rst_flush_gated", {31'b0, cs_flush}, 32'd0);
    chk("rst_fencei_gated", {31'b0, fencei}, 32'd0);
    @(posedge clock); #1;
    reset = 0;
    chk("rst2_ready", {31'b0, in_ready}, 32'd1);
    chk("rst2_dnpc", cs_dnpc, 32'd0);
    rd("rst2_mstatus", 12'h300, 32'h0000_1800);
    rd("rst2_mtvec", 12'h305, 32'd0);
    repeat (3) @(posedge clock);
    #1;

    chk("gpr_queue_empty", gq.size(), 32'd0);
    chk("flush_queue_empty", fq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
